mux_rr_nch: RTL and testbench

MUX_RR_NCH -- requirements
Module: mux_rr_nch

---
 rtl/muxn_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/mux_rr_nch.sv | 95 +++++++++
 tb/tb_mux_rr_nch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-channel output multiplexer: mode encodings,
// counter width and a saturating increment helper.
package muxn_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   localparam int CNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for mux_rr_nch: direct channel select or round-robin search
// from a rotating pointer that advances past each accepted channel.
module rr_arbiter
   import muxn_pkg::*;
#(
   parameter  int NCH   = 2,
   localparam int IDX_W = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   i_valid,
   input  logic             i_mode,
   input  logic [2:0]       i_sel,
   input  logic             i_accept,
   output logic             o_grantVld,
   output logic [IDX_W-1:0] o_grantIdx
);

   logic [IDX_W-1:0] r_rrPtr;
   logic             w_rrVld;
   logic [IDX_W-1:0] w_rrIdx;
   logic             w_dirVld;
   logic [IDX_W-1:0] w_dirIdx;
   logic             w_isRr;

   assign w_isRr = (mode_e'(i_mode) == MODE_RR);

   // First valid channel at or above the pointer, wrapping past the top channel.
   always_comb begin : rrSearch
      int j;
      w_rrVld = 1'b0;
      w_rrIdx = '0;
      j       = 0;
      for (int k = 0; k < NCH; k++) begin
         j = int'(r_rrPtr) + k;
         if (j >= NCH) j = j - NCH;
         if (!w_rrVld && i_valid[j]) begin
            w_rrVld = 1'b1;
            w_rrIdx = IDX_W'(j);
         end
      end
   end

   always_comb begin : directSelect
      w_dirVld = 1'b0;
      w_dirIdx = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(i_sel) == k) begin
            w_dirVld = i_valid[k];
            w_dirIdx = IDX_W'(k);
         end
      end
   end

   assign o_grantVld = w_isRr ? w_rrVld : w_dirVld;
   assign o_grantIdx = w_isRr ? w_rrIdx : w_dirIdx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rrPtr <= '0;
      end else if (w_isRr && i_accept) begin
         r_rrPtr <= (int'(o_grantIdx) == NCH - 1) ? '0 : o_grantIdx + 1'b1;
      end
   end

endmodule

// File: rtl/mux_rr_nch.sv
// N-channel valid/ready multiplexer with a one-word registered output stage.
// Define MUX_RR_NCH_CNT_EN to add the saturating output transfer counter xfer_cnt.
module mux_rr_nch
   import muxn_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int NCH   = 2,
   localparam int IDX_W = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [2:0]           sel,
   output logic [WIDTH-1:0]     data_out,
   output logic                 valid_out,
   input  logic                 out_ready
`ifdef MUX_RR_NCH_CNT_EN
   ,
   output logic [CNT_W-1:0]     xfer_cnt
`endif
);

   logic             r_validOut;
   logic [WIDTH-1:0] r_dataOut;
   logic             w_space;
   logic             w_xfer;
   logic             w_grantVld;
   logic [IDX_W-1:0] w_grantIdx;
   logic [WIDTH-1:0] w_selData;

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .i_valid    (in_valid),
      .i_mode     (mode),
      .i_sel      (sel),
      .i_accept   (w_xfer),
      .o_grantVld (w_grantVld),
      .o_grantIdx (w_grantIdx)
   );

   // The output register can take a word when empty or draining this cycle.
   assign w_space = !r_validOut || out_ready;
   assign w_xfer  = w_grantVld && w_space;

   always_comb begin
      in_ready  = '0;
      w_selData = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(w_grantIdx) == k) begin
            w_selData   = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = w_xfer && !reset;
         end
      end
   end

   // Data is zeroed whenever the stage empties so data_out reads 0 while invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_validOut <= 1'b0;
         r_dataOut  <= '0;
      end else if (w_space) begin
         if (w_xfer) begin
            r_validOut <= 1'b1;
            r_dataOut  <= w_selData;
         end else begin
            r_validOut <= 1'b0;
            r_dataOut  <= '0;
         end
      end
   end

   assign valid_out = r_validOut;
   assign data_out  = r_dataOut;

`ifdef MUX_RR_NCH_CNT_EN
   logic [CNT_W-1:0] r_xferCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_xferCnt <= '0;
      end else if (r_validOut && out_ready) begin
         r_xferCnt <= satInc(r_xferCnt);
      end
   end

   assign xfer_cnt = r_xferCnt;
`endif

endmodule

// File: tb/tb_mux_rr_nch.sv
// Self-checking bench for mux_rr_nch: directed vectors, corner sequences and
// randomized traffic compared against a behavioural model of the grant rules.
module tb_mux_rr_nch;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] inData;
   logic [3:0]  inValid;
   logic [3:0]  inReady;
   logic        mode;
   logic [2:0]  sel;
   logic [3:0]  dataOut;
   logic        validOut;
   logic        outReady;
`ifdef MUX_RR_NCH_CNT_EN
   logic [15:0] xferCnt;
`endif

   logic [7:0]  inData2;
   logic [1:0]  inValid2;
   logic [1:0]  inReady2;
   logic        mode2;
   logic [2:0]  sel2;
   logic [3:0]  dataOut2;
   logic        validOut2;
   logic        outReady2;

   int testsRun    = 0;
   int testsFailed = 0;

   int mPtr;
   bit mValid;
   int mData;

   typedef struct {
      int          sel;
      logic [3:0]  valid;
      logic [15:0] data;
      int          expReady;
      int          expValid;
      int          expData;
   } vec_t;

   vec_t vecs[7];

   mux_rr_nch #(
      .WIDTH (4),
      .NCH   (4)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .mode      (mode),
      .sel       (sel),
      .data_out  (dataOut),
      .valid_out (validOut),
      .out_ready (outReady)
`ifdef MUX_RR_NCH_CNT_EN
      ,
      .xfer_cnt  (xferCnt)
`endif
   );

   mux_rr_nch #(
      .WIDTH (4),
      .NCH   (2)
   ) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .in_data   (inData2),
      .in_valid  (inValid2),
      .in_ready  (inReady2),
      .mode      (mode2),
      .sel       (sel2),
      .data_out  (dataOut2),
      .valid_out (validOut2),
      .out_ready (outReady2)
`ifdef MUX_RR_NCH_CNT_EN
      ,
      .xfer_cnt  ()
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one word of storage; grant follows the mode rules, with the
   // round-robin pointer moving only on an accepted round-robin transfer.
   task automatic modelStep(input bit m, input int s, input logic [3:0] v, input logic [15:0] d,
                            input bit ordy, output int expReady, output int expValid, output int expData);
      int  g;
      bit  space;
      g     = -1;
      space = !mValid || ordy;
      if (!m) begin
         if (s < 4) begin
            if (v[s]) g = s;
         end
      end else begin
         for (int k = 0; k < 4; k++)
            if (g < 0 && v[(mPtr + k) % 4]) g = (mPtr + k) % 4;
      end
      expReady = (space && g >= 0) ? (1 << g) : 0;
      if (space) begin
         if (g >= 0) begin
            mValid = 1'b1;
            mData  = int'((d >> (4 * g)) & 16'hF);
            if (m) mPtr = (g + 1) % 4;
         end else begin
            mValid = 1'b0;
            mData  = 0;
         end
      end
      expValid = int'(mValid);
      expData  = mData;
   endtask

   task automatic modelReset();
      mPtr   = 0;
      mValid = 1'b0;
      mData  = 0;
   endtask

   task automatic applyStimulus(input bit m, input int s, input logic [3:0] v, input logic [15:0] d,
                                input bit ordy, output logic [31:0] rdyAct,
                                output logic [31:0] vldAct, output logic [31:0] datAct);
      mode     = m;
      sel      = s[2:0];
      inValid  = v;
      inData   = d;
      outReady = ordy;
      #3;
      rdyAct = 32'(inReady);
      @(posedge clk);
      #1;
      vldAct = 32'(validOut);
      datAct = 32'(dataOut);
   endtask

   task automatic runCycle(input string name, input bit m, input int s, input logic [3:0] v,
                           input logic [15:0] d, input bit ordy, output logic [31:0] rdyAct,
                           output logic [31:0] vldAct, output logic [31:0] datAct);
      int eR, eV, eD;
      modelStep(m, s, v, d, ordy, eR, eV, eD);
      applyStimulus(m, s, v, d, ordy, rdyAct, vldAct, datAct);
      checkOutput({name, "_in_ready"}, rdyAct, eR);
      checkOutput({name, "_valid_out"}, vldAct, eV);
      checkOutput({name, "_data_out"}, datAct, eD);
   endtask

   initial begin
      logic [31:0] r, v, d;

      vecs[0] = '{0, 4'b0001, 16'h4321, 'h1, 1, 'h1};
      vecs[1] = '{2, 4'b0100, 16'h4321, 'h4, 1, 'h3};
      vecs[2] = '{3, 4'b1111, 16'hBEEF, 'h8, 1, 'hB};
      vecs[3] = '{2, 4'b1011, 16'hBEEF, 'h0, 0, 'h0};
      vecs[4] = '{5, 4'b1111, 16'hBEEF, 'h0, 0, 'h0};
      vecs[5] = '{7, 4'b1111, 16'h1234, 'h0, 0, 'h0};
      vecs[6] = '{1, 4'b0010, 16'h00A0, 'h2, 1, 'hA};

      // Reset with traffic pending: nothing may be accepted or presented.
      reset     = 1'b1;
      mode      = 1'b1;
      sel       = 3'd0;
      inValid   = 4'hF;
      inData    = 16'hFFFF;
      outReady  = 1'b1;
      mode2     = 1'b0;
      sel2      = 3'd0;
      inValid2  = 2'b00;
      inData2   = 8'h00;
      outReady2 = 1'b1;
      modelReset();
      #12;
      checkOutput("reset_in_ready", 32'(inReady), 0);
      checkOutput("reset_valid_out", 32'(validOut), 0);
      checkOutput("reset_data_out", 32'(dataOut), 0);
      inValid = 4'h0;
      #5;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two-channel direct select of channel 1.
      sel2     = 3'd1;
      inValid2 = 2'b11;
      inData2  = 8'hA5;
      #3;
      checkOutput("direct2_in_ready", 32'(inReady2), 'h2);
      @(posedge clk);
      #1;
      checkOutput("direct2_valid_out", 32'(validOut2), 1);
      checkOutput("direct2_data_out", 32'(dataOut2), 'hA);
      inValid2 = 2'b00;

      // Round-robin fairness with every channel requesting.
      for (int i = 0; i < 5; i++) begin
         runCycle("rr_fair", 1'b1, 0, 4'hF, 16'h3210, 1'b1, r, v, d);
         checkOutput("rr_fair_grant_ready", r, 1 << (i % 4));
         checkOutput("rr_fair_grant_data", d, i % 4);
      end

      // Backpressure: word holds, nothing accepted, pointer frozen.
      runCycle("bp_load", 1'b1, 0, 4'hF, 16'h7654, 1'b1, r, v, d);
      checkOutput("bp_load_data", d, 'h5);
      for (int i = 0; i < 3; i++) begin
         runCycle("bp_stall", 1'b1, 0, 4'hF, 16'h7654, 1'b0, r, v, d);
         checkOutput("bp_stall_ready", r, 0);
         checkOutput("bp_stall_data", d, 'h5);
         checkOutput("bp_stall_valid", v, 1);
      end
      runCycle("bp_release", 1'b1, 0, 4'hF, 16'h7654, 1'b1, r, v, d);
      checkOutput("bp_release_ready", r, 'h4);
      checkOutput("bp_release_data", d, 'h6);
      checkOutput("bp_release_valid", v, 1);
      runCycle("bp_next", 1'b1, 0, 4'hF, 16'h7654, 1'b1, r, v, d);
      checkOutput("bp_next_ready", r, 'h8);
      checkOutput("bp_next_data", d, 'h7);

      // Idle drain.
      runCycle("idle", 1'b1, 0, 4'h0, 16'h7654, 1'b1, r, v, d);
      checkOutput("idle_valid", v, 0);
      checkOutput("idle_data", d, 0);
      checkOutput("idle_ready", r, 0);

      // Direct-mode vector table, including out-of-range selects.
      for (int i = 0; i < 7; i++) begin
         runCycle("table", 1'b0, vecs[i].sel, vecs[i].valid, vecs[i].data, 1'b1, r, v, d);
         checkOutput($sformatf("table%0d_ready", i), r, vecs[i].expReady);
         checkOutput($sformatf("table%0d_valid", i), v, vecs[i].expValid);
         checkOutput($sformatf("table%0d_data", i), d, vecs[i].expData);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         runCycle("rand", 1'($urandom), int'($urandom_range(0, 7)), 4'($urandom),
                  16'($urandom), ($urandom_range(0, 9) < 7), r, v, d);
      end

      // Reset between edges with a word held; first grant afterwards is channel 0.
      runCycle("mid_load", 1'b1, 0, 4'b0100, 16'h0900, 1'b1, r, v, d);
      checkOutput("mid_load_data", d, 'h9);
      outReady = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_valid", 32'(validOut), 0);
      checkOutput("mid_reset_data", 32'(dataOut), 0);
      checkOutput("mid_reset_ready", 32'(inReady), 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      modelReset();
      runCycle("post_reset", 1'b1, 0, 4'hF, 16'hDCBA, 1'b1, r, v, d);
      checkOutput("post_reset_ready", r, 'h1);
      checkOutput("post_reset_data", d, 'hA);

`ifdef MUX_RR_NCH_CNT_EN
      // Counter: counts output transfers from reset and saturates.
      #2;
      reset = 1'b1;
      #1;
      checkOutput("cnt_reset", 32'(xferCnt), 0);
      @(posedge clk);
      #3;
      reset    = 1'b0;
      mode     = 1'b1;
      inValid  = 4'hF;
      outReady = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("cnt_ten", 32'(xferCnt), 9);
      repeat (70000) @(posedge clk);
      #1;
      checkOutput("cnt_saturate", 32'(xferCnt), 'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
